// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: datapath width, base opcodes, fetch FSM states.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC select: redirect beats sequential pc+4.
// INSTR_FETCH_MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_VEC and pulse misalign.
module fetch_pc_reg #(
  parameter int               XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_en,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            mis_d, mis_q;

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (redir_en) begin
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      if (redir_pc[1:0] != 2'b00) begin
        pc_d  = TRAP_VEC;
        mis_d = 1'b1;
      end else begin
        pc_d  = redir_pc;
      end
`else
      // low bits dropped so the fetch address stays word aligned
      pc_d = redir_pc & ~XLEN'(3);
`endif
    end else if (inc_en) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = mis_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: imem valid/ready request, captured word held for decode.
// INSTR_FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap (see fetch_pc_reg).
module instr_fetch #(
  parameter int               XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign
);
  import rv_pkg::*;

  fetch_state_e    state_d, state_q;
  logic            kill_d, kill_q;
  logic            req_valid_d, req_valid_q;
  logic            instr_valid_d, instr_valid_q;
  logic [31:0]     instr_d, instr_q;
  logic [XLEN-1:0] instr_pc_d, instr_pc_q;
  logic [6:0]      opcode_d, opcode_q;
  logic            pc_inc, redir_en;
  logic [XLEN-1:0] pc;

  assign redir_en = redirect_valid && (state_q != IDLE);

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    , .TRAP_VEC (TRAP_VEC)
`endif
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (pc_inc),
    .redir_en (redir_en),
    .redir_pc (redirect_pc),
    .pc       (pc),
    .misalign (fetch_misalign)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_inc     = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // a redirect racing the accept kills the request already on its way
        if (imem_req_ready) begin
          state_d = WAIT;
          kill_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = REQ;
          end else begin
            instr_d    = imem_rsp_data;
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      HOLD: if (redirect_valid || instr_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase
    req_valid_d   = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
    opcode_d      = instr_valid_d ? opcode_of(instr_d) : 7'b0000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kill_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      opcode_q      <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      opcode_q      <= opcode_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = opcode_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM-backed memory responder, scoreboard of delivered words, vector table plus corner sequences.
module tb_instr_fetch;
  import rv_pkg::*;

  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  typedef struct { logic [31:0] addr; logic [6:0] opc; } vec_t;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_ADDR  = 32'h0000_0100;
  localparam logic [31:0] MIS_PULSE = 32'd1;
`else
  localparam logic [31:0] MIS_ADDR  = 32'h0000_0040;
  localparam logic [31:0] MIS_PULSE = 32'd0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, rdy, rsp_v, instr_valid, irdy, redir_v, fetch_misalign;
  logic [31:0] imem_req_addr, rsp_d, instr, instr_pc, redir_pc;
  logic [6:0]  opcode;

  logic [31:0] rom [16];
  exp_t        sb[$];
  vec_t        vecs[11];
  int          n_chk = 0, n_fail = 0;
  int          mem_delay = 0, pend_wait = 0;
  logic        pend = 1'b0, pend_drop = 1'b0, rsp_drop = 1'b0;
  logic [31:0] pend_addr = '0, rsp_pc = '0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(rdy), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(rsp_v), .imem_rsp_data(rsp_d),
    .instr_valid(instr_valid), .instr_ready(irdy), .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
    .redirect_valid(redir_v), .redirect_pc(redir_pc), .fetch_misalign(fetch_misalign)
  );

  function automatic logic [31:0] memw(input logic [3:0] idx);
    return rom[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // One clock: settle scoreboard/memory bookkeeping for the coming edge, then sample.
  task automatic cyc();
    exp_t e;
    if (rsp_v && !rsp_drop && !redir_v) begin
      e.pc = rsp_pc; e.w = rsp_d;
      sb.push_back(e);
    end
    if (instr_valid && (irdy || redir_v) && sb.size() != 0) void'(sb.pop_front());
    if (pend && redir_v) pend_drop = 1'b1;
    if (imem_req_valid && rdy) begin
      pend = 1'b1; pend_wait = mem_delay; pend_addr = imem_req_addr; pend_drop = redir_v;
    end
    @(posedge clk); #1;
    rsp_v = 1'b0;
    if (pend) begin
      if (pend_wait == 0) begin
        rsp_v = 1'b1; rsp_d = memw(pend_addr[5:2]); rsp_pc = pend_addr; rsp_drop = pend_drop;
        pend = 1'b0;
      end else pend_wait--;
    end
    if (instr_valid) begin
      if (sb.size() == 0) fail_now($sformatf("unexpected_instr_valid pc %h", instr_pc));
      else begin
        chk("sb_instr", instr, sb[0].w);
        chk("sb_pc", instr_pc, sb[0].pc);
        chk("sb_opcode", 32'(opcode), 32'(sb[0].w[6:0]));
      end
    end else chk("opcode_idle", 32'(opcode), 32'd0);
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!imem_req_valid && k < 20) begin cyc(); k++; end
    if (!imem_req_valid) fail_now({nm, " timeout waiting for imem_req_valid"});
  endtask

  task automatic wait_instr(input string nm);
    int k = 0;
    while (!instr_valid && k < 20) begin cyc(); k++; end
    if (!instr_valid) fail_now({nm, " timeout waiting for instr_valid"});
  endtask

  task automatic wait_in_wait(input string nm);
    int k = 0;
    while (!(pend && !imem_req_valid) && k < 20) begin cyc(); k++; end
    if (!(pend && !imem_req_valid)) fail_now({nm, " timeout waiting for outstanding fetch"});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({nm, "_req_addr"}, imem_req_addr, 32'h0);
    chk({nm, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_instr_pc"}, instr_pc, 32'h0);
    chk({nm, "_opcode"}, 32'(opcode), 32'd0);
    chk({nm, "_misalign"}, 32'(fetch_misalign), 32'd0);
  endtask

  initial begin
    int seen;
    rom[0]  = 32'h00500093; rom[1]  = 32'h00500093; rom[2]  = 32'h00500093;
    rom[3]  = 32'h002081b3; rom[4]  = 32'h0000a103; rom[5]  = 32'h0020a223;
    rom[6]  = 32'h00208463; rom[7]  = 32'h008000ef; rom[8]  = 32'h000080e7;
    rom[9]  = 32'h123450b7; rom[10] = 32'h00001097;
    for (int i = 11; i < 16; i++) rom[i] = 32'h00000013;
    vecs[0]  = '{32'h00, OPC_ITYPE};  vecs[1]  = '{32'h04, OPC_ITYPE};
    vecs[2]  = '{32'h08, OPC_ITYPE};  vecs[3]  = '{32'h0c, OPC_RTYPE};
    vecs[4]  = '{32'h10, OPC_LOAD};   vecs[5]  = '{32'h14, OPC_STORE};
    vecs[6]  = '{32'h18, OPC_BRANCH}; vecs[7]  = '{32'h1c, OPC_JAL};
    vecs[8]  = '{32'h20, OPC_JALR};   vecs[9]  = '{32'h24, OPC_LUI};
    vecs[10] = '{32'h28, OPC_AUIPC};

    rdy = 1'b1; irdy = 1'b1; rsp_v = 1'b0; rsp_d = '0; redir_v = 1'b0; redir_pc = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;

    // Straight-line fetch, memory always ready
    for (int i = 0; i < 11; i++) begin
      wait_req("vec");
      chk("vec_req_addr", imem_req_addr, vecs[i].addr);
      wait_instr("vec");
      chk("vec_instr_pc", instr_pc, vecs[i].addr);
      chk("vec_opcode", 32'(opcode), 32'(vecs[i].opc));
    end

    // Downstream back-pressure for 5 cycles
    wait_req("bp");
    irdy = 1'b0;
    wait_instr("bp");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
      chk("bp_instr_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr_pc", instr_pc, 32'h2c);
      chk("bp_opcode", 32'(opcode), 32'(OPC_ITYPE));
    end
    irdy = 1'b1;
    cyc();
    chk("bp_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("bp_resume_addr", imem_req_addr, 32'h30);

    // Redirect during WAIT, response arrives one cycle later and must be dropped
    mem_delay = 1;
    wait_in_wait("wait_redir");
    redir_v = 1'b1; redir_pc = 32'h40;
    cyc();
    redir_v = 1'b0; mem_delay = 0;
    seen = 0;
    for (int k = 0; k < 10 && !imem_req_valid; k++) begin
      cyc();
      if (instr_valid) seen++;
    end
    chk("wait_redir_dropped", 32'(seen), 32'd0);
    chk("wait_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wait_redir_addr", imem_req_addr, 32'h40);

    // Redirect in HOLD with instr_ready in the same cycle
    wait_instr("hold_redir");
    chk("hold_redir_pc0", instr_pc, 32'h40);
    redir_v = 1'b1; redir_pc = 32'h80;
    cyc();
    redir_v = 1'b0;
    chk("hold_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("hold_redir_addr", imem_req_addr, 32'h80);
    chk("hold_redir_no_dup", 32'(instr_valid), 32'd0);
    wait_instr("hold_redir");
    chk("hold_redir_pc1", instr_pc, 32'h80);

    // Misaligned redirect while REQ is stalled
    rdy = 1'b0;
    wait_req("mis");
    redir_v = 1'b1; redir_pc = 32'h42;
    cyc();
    redir_v = 1'b0;
    chk("mis_addr", imem_req_addr, MIS_ADDR);
    chk("mis_pulse", 32'(fetch_misalign), MIS_PULSE);
    cyc();
    chk("mis_pulse_end", 32'(fetch_misalign), 32'd0);
    chk("mis_addr_hold", imem_req_addr, MIS_ADDR);
    rdy = 1'b1;
    wait_instr("mis");
    chk("mis_instr_pc", instr_pc, MIS_ADDR);

    // Reset during WAIT, then a late response
    mem_delay = 1;
    wait_in_wait("rst");
    rst_n = 1'b0;
    #1 chk_reset("midrst");
    pend = 1'b0; sb.delete(); mem_delay = 0;
    cyc();
    rst_n = 1'b1;
    rsp_v = 1'b1; rsp_d = 32'hdeadbeef; rsp_drop = 1'b1;
    cyc();
    rdy = 1'b0;
    rsp_v = 1'b1; rsp_d = 32'hdeadbeef; rsp_drop = 1'b1;
    cyc();
    chk("rst_restart_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_restart_addr", imem_req_addr, 32'h0);
    chk("rst_late_rsp_ignored", 32'(instr_valid), 32'd0);
    rdy = 1'b1;
    wait_instr("rst");
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr", instr, 32'h00500093);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
